// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction-fetch stage owning the PC, issuing sequential
//            requests to a 1-cycle-latency memory and buffering the returned
//            {inst, pc} pairs in a DEPTH-entry FIFO drained by decode.
// Revision : 1.0  initial release
// ============================================================================
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [31:0]                inst,
    output logic [XLEN-1:0]            inst_pc,
    output logic [XLEN-1:0]            inst_pc4,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int             CNT_W   = $clog2(DEPTH + 1);
    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W:0] C_DEPTH = (CNT_W + 1)'(DEPTH);

    logic [XLEN-1:0]  pc_q,         pc_d;
    logic             pending_q,    pending_d;
    logic [XLEN-1:0]  pending_pc_q, pending_pc_d;
    logic [PTR_W-1:0] rd_ptr_q,     rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,     wr_ptr_d;
    logic [CNT_W-1:0] count_q,      count_d;

    logic [31:0]      inst_mem_q [DEPTH];
    logic [XLEN-1:0]  pc_mem_q   [DEPTH];

    logic [CNT_W:0]   inflight;
    logic             issue;
    logic             push;
    logic             pop;

    // Credit counts both stored entries and the response still in flight,
    // so a push can never land on a full queue.
    assign inflight = {1'b0, count_q} + {{CNT_W{1'b0}}, pending_q};
    assign issue    = reset && !redirect && (inflight < C_DEPTH);
    assign push     = pending_q && !redirect;
    assign pop      = inst_valid && inst_ready;

    assign imem_req   = issue;
    assign imem_addr  = pc_q;
    assign inst_valid = (count_q != '0) && !redirect;
    assign inst       = inst_mem_q[rd_ptr_q];
    assign inst_pc    = pc_mem_q[rd_ptr_q];
    assign inst_pc4   = inst_pc + XLEN'(4);
    assign count      = count_q;

    always_comb begin
        pc_d         = pc_q;
        pending_d    = 1'b0;
        pending_pc_d = pending_pc_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;

        if (redirect) begin
            pc_d     = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                pc_d         = pc_q + XLEN'(4);
                pending_d    = 1'b1;
                pending_pc_d = pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q         <= RESET_PC;
            pending_q    <= 1'b0;
            pending_pc_q <= RESET_PC;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            pc_q         <= pc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage is intentionally left unreset; occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]   <= pending_pc_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Self-checking bench for fetch_queue: vector table, queue-based
//            reference model under random traffic, async reset sequence.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_ready;

    logic             req0, valid0;
    logic [31:0]      addr0, rdata0, inst0, pc0, pc40;
    logic [CNT_W-1:0] cnt0;

    logic             req1, valid1;
    logic [31:0]      addr1, rdata1, inst1, pc1, pc41;
    logic [CNT_W-1:0] cnt1;
    logic             one_b   = 1'b1;
    logic             zero_b  = 1'b0;
    logic [31:0]      zero_pc = '0;

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .imem_req(req0), .imem_addr(addr0),
        .imem_rdata(rdata0), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(valid0), .inst_ready(inst_ready), .inst(inst0),
        .inst_pc(pc0), .inst_pc4(pc40), .count(cnt0)
    );

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset), .imem_req(req1), .imem_addr(addr1),
        .imem_rdata(rdata1), .redirect(zero_b), .redirect_pc(zero_pc),
        .inst_valid(valid1), .inst_ready(one_b), .inst(inst1),
        .inst_pc(pc1), .inst_pc4(pc41), .count(cnt1)
    );

    // Synchronous memory: data for the address presented in the previous cycle.
    always @(posedge clk) begin
        rdata0 <= addr0 ^ 32'hA5A5_0000;
        rdata1 <= addr1 ^ 32'hA5A5_0000;
    end

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_ppc;
    bit          m_pend;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc   = 32'h0;
        m_ppc  = 32'h0;
        m_pend = 1'b0;
    endtask

    task automatic model_check();
        bit e_req;
        bit e_valid;
        e_req   = (mq.size() + int'(m_pend) < DEPTH) && !redirect;
        e_valid = (mq.size() != 0) && !redirect;
        chk("req", 32'(req0), 32'(e_req));
        if (e_req) chk("addr", addr0, m_pc);
        chk("valid", 32'(valid0), 32'(e_valid));
        chk("count", 32'(cnt0), 32'(mq.size()));
        if (e_valid) begin
            chk("inst", inst0, mq[0].inst);
            chk("inst_pc", pc0, mq[0].pc);
            chk("inst_pc4", pc40, mq[0].pc + 32'd4);
        end
    endtask

    task automatic model_step(input bit red, input logic [31:0] rpc, input bit rdy);
        bit e_req;
        bit e_valid;
        if (red) begin
            mq.delete();
            m_pend = 1'b0;
            m_pc   = rpc;
        end else begin
            e_req   = (mq.size() + int'(m_pend) < DEPTH);
            e_valid = (mq.size() != 0);
            if (e_valid && rdy) void'(mq.pop_front());
            if (m_pend) mq.push_back('{inst: m_ppc ^ 32'hA5A5_0000, pc: m_ppc});
            if (e_req) begin
                m_pend = 1'b1;
                m_ppc  = m_pc;
                m_pc   = m_pc + 32'd4;
            end else begin
                m_pend = 1'b0;
            end
        end
    endtask

    task automatic cycle(input bit red, input logic [31:0] rpc, input bit rdy);
        redirect    = red;
        redirect_pc = rpc;
        inst_ready  = rdy;
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
        model_step(red, rpc, rdy);
    endtask

    typedef struct {
        bit          rdy;
        bit          red;
        logic [31:0] rpc;
        bit          req;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] pc;
        int          cnt;
    } vec_t;

    vec_t        tbl[18];
    logic [31:0] wrap_pc[4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};

    initial begin
        // rdy red rpc      req addr      valid pc       cnt
        tbl[0]  = '{0, 0, 32'h0,   1, 32'h0,   0, 32'h0,   0};
        tbl[1]  = '{0, 0, 32'h0,   1, 32'h4,   0, 32'h0,   0};
        tbl[2]  = '{0, 0, 32'h0,   1, 32'h8,   1, 32'h0,   1};
        tbl[3]  = '{0, 0, 32'h0,   1, 32'hC,   1, 32'h0,   2};
        tbl[4]  = '{0, 0, 32'h0,   0, 32'h0,   1, 32'h0,   3};
        tbl[5]  = '{0, 0, 32'h0,   0, 32'h0,   1, 32'h0,   4};
        tbl[6]  = '{0, 0, 32'h0,   0, 32'h0,   1, 32'h0,   4};
        tbl[7]  = '{1, 0, 32'h0,   0, 32'h0,   1, 32'h0,   4};
        tbl[8]  = '{1, 0, 32'h0,   1, 32'h10,  1, 32'h4,   3};
        tbl[9]  = '{1, 1, 32'h100, 0, 32'h0,   0, 32'h0,   2};
        tbl[10] = '{1, 0, 32'h0,   1, 32'h100, 0, 32'h0,   0};
        tbl[11] = '{1, 0, 32'h0,   1, 32'h104, 0, 32'h0,   0};
        tbl[12] = '{1, 0, 32'h0,   1, 32'h108, 1, 32'h100, 1};
        tbl[13] = '{1, 1, 32'h200, 0, 32'h0,   0, 32'h0,   1};
        tbl[14] = '{1, 1, 32'h300, 0, 32'h0,   0, 32'h0,   0};
        tbl[15] = '{1, 0, 32'h0,   1, 32'h300, 0, 32'h0,   0};
        tbl[16] = '{1, 0, 32'h0,   1, 32'h304, 0, 32'h0,   0};
        tbl[17] = '{1, 0, 32'h0,   1, 32'h308, 1, 32'h300, 1};

        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(valid0), 32'd0);
        chk("rst_req", 32'(req0), 32'd0);
        chk("rst_count", 32'(cnt0), 32'd0);
        chk("rst_addr", addr0, 32'h0);
        chk("rst_addr_wrap", addr1, 32'hFFFF_FFF8);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();

        for (int i = 0; i < 18; i++) begin
            redirect    = tbl[i].red;
            redirect_pc = tbl[i].rpc;
            inst_ready  = tbl[i].rdy;
            @(negedge clk);
            model_check();
            chk("tbl_req", 32'(req0), 32'(tbl[i].req));
            if (tbl[i].req) chk("tbl_addr", addr0, tbl[i].addr);
            chk("tbl_valid", 32'(valid0), 32'(tbl[i].valid));
            chk("tbl_count", 32'(cnt0), 32'(tbl[i].cnt));
            if (tbl[i].valid) begin
                chk("tbl_pc", pc0, tbl[i].pc);
                chk("tbl_inst", inst0, tbl[i].pc ^ 32'hA5A5_0000);
            end
            if (i >= 2 && i <= 5) begin
                chk("wrap_valid", 32'(valid1), 32'd1);
                chk("wrap_pc", pc1, wrap_pc[i-2]);
                chk("wrap_pc4", pc41, wrap_pc[i-2] + 32'd4);
            end
            @(posedge clk);
            #1;
            model_step(tbl[i].red, tbl[i].rpc, tbl[i].rdy);
        end

        // Random traffic with a ready density that changes per block.
        for (int blk = 0; blk < 10; blk++) begin
            int rdy_pct;
            rdy_pct = int'($urandom_range(0, 100));
            for (int c = 0; c < 64; c++) begin
                cycle($urandom_range(0, 99) < 5, $urandom,
                      $urandom_range(0, 99) < rdy_pct);
            end
        end

        // Fill the queue, then drop reset between clock edges.
        repeat (8) cycle(1'b0, 32'h0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_valid", 32'(valid0), 32'd0);
        chk("async_req", 32'(req0), 32'd0);
        chk("async_count", 32'(cnt0), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        repeat (8) cycle(1'b0, 32'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
